mem_stage_ctrl: RTL
===================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter DW, default 32, word_t width; all data/address ports are word_t.
REQ-002 Parameter PCW, default 16, width of the stall-cycle counter.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low. Ports are CLK and nRST.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 nRST  in  1  async active-low reset.
REQ-006 ex_valid  in  1  EX/MEM holds a valid instruction.
REQ-007 pc_EX, alu_out_EX, store_EX, imm_EX  in  DW each  EX/MEM payload.
REQ-008 wsel_EX  in  5; MemtoReg_EX, RegWr_EX, MemRead_EX, MemWrite_EX  in  1 each; WriteSrc_EX  in  2.
REQ-009 flush_in  in  1  hazard-unit flush of the MEM stage.
REQ-010 hold_in  in  1  downstream hold; MEM/WB must not load.
REQ-011 dhit  in  1  dcache completion; dmemload  in  DW  read data.
REQ-012 dREN, dWEN  out  1  dcache read/write request; dmemaddr, dmemstore  out  DW.
REQ-013 dcache_active  out  2  {dWEN, dREN}.
REQ-014 pc_MEM, dmem_out, alu_out_MEM, imm_MEM  out  DW; wsel_MEM  out  5; MemtoReg_MEM, RegWr_MEM  out  1; WriteSrc_MEM  out  2: MEM/WB register inputs.
REQ-015 pipeline_ctrl  out  2  MEM/WB control: 2'b00 load, 2'b01 hold, 2'b10 bubble.
REQ-016 mem_stall  out  1  freeze IF..EX/MEM.
REQ-017 stall_cnt  out  PCW  saturating count of mem_stall cycles.

Function
REQ-018 States IDLE, WAIT, DONE; encoding free.
REQ-019 Mem op = ex_valid & (MemRead_EX | MemWrite_EX); MemRead_EX & MemWrite_EX both high is treated as write only.
REQ-020 IDLE, no mem op: requests low; pipeline_ctrl = 2'b00; mem_stall = 0; payload passes through combinationally.
REQ-021 IDLE, mem op: dREN/dWEN asserted same cycle (Mealy); dmemaddr = alu_out_EX; dmemstore = store_EX.
REQ-022 IDLE, mem op, dhit same cycle, hold_in = 0: dmem_out = dmemload; pipeline_ctrl = 2'b00; stay IDLE; zero stall.
REQ-023 IDLE, mem op, dhit = 0: mem_stall = 1; pipeline_ctrl = 2'b10; next state WAIT.
REQ-024 WAIT: request and address held stable; mem_stall = 1; pipeline_ctrl = 2'b10 until dhit.
REQ-025 WAIT, dhit, hold_in = 0: dmem_out = dmemload; pipeline_ctrl = 2'b00; mem_stall = 0; next IDLE.
REQ-026 dhit with hold_in = 1 (IDLE or WAIT): capture dmemload into load buffer; drop request next cycle; next DONE.
REQ-027 DONE: requests low; dmem_out = load buffer; pipeline_ctrl = 2'b01, mem_stall = 1 while hold_in; hold_in falls -> pipeline_ctrl = 2'b00, mem_stall = 0, next IDLE.
REQ-028 hold_in with no outstanding op: pipeline_ctrl = 2'b01, mem_stall = 1, no state change.
REQ-029 flush_in in IDLE or on a read in WAIT: pipeline_ctrl = 2'b10; requests low same cycle; next IDLE; dhit that cycle ignored.
REQ-030 flush_in during a write in WAIT: write not aborted; flush is latched; on dhit, pipeline_ctrl = 2'b10 and next IDLE.
REQ-031 flush_in in DONE: buffer discarded; pipeline_ctrl = 2'b10; next IDLE.
REQ-032 flush_in takes priority over hold_in.
REQ-033 dhit with no request outstanding is ignored.
REQ-034 stall_cnt increments each cycle mem_stall = 1; saturates at all-ones, no wrap.
REQ-035 Payload outputs in WAIT/DONE come from registers captured at request issue, not from live EX inputs.

Reset
REQ-036 nRST low: state IDLE; dREN = dWEN = 0; load buffer, flush latch, captured payload and stall_cnt = 0; pipeline_ctrl = 2'b00; mem_stall = 0.
REQ-037 Reset mid-WAIT drops requests immediately (asynchronously); a dhit after release is ignored.

Verification
REQ-038 Load, alu_out_EX=0x100, dhit 3 cycles late, dmemload=0xDEADBEEF -> dREN 4 cycles, pipeline_ctrl 10,10,10,00, dmem_out=0xDEADBEEF, stall_cnt=3.
REQ-039 Store, dhit same cycle -> dWEN 1 cycle, dcache_active=2'b10, pipeline_ctrl 00, mem_stall never high.
REQ-040 Load, hold_in high at dhit for 2 cycles, dmemload=0x1234 -> DONE, pipeline_ctrl 01,01 then 00, dmem_out=0x1234 throughout, dREN low after capture.
REQ-041 Flush during read WAIT -> dREN low same cycle, pipeline_ctrl 10, IDLE; later dhit no effect.
REQ-042 Flush during write WAIT, dhit 2 cycles later -> dWEN held until dhit, pipeline_ctrl 10 at completion.
REQ-043 nRST low during WAIT; stall_cnt forced to all-ones first -> outputs at reset values, stall_cnt=0; separately, saturation holds at all-ones.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues dcache requests, stalls the front of the pipeline
// until completion, and produces the MEM/WB register inputs and load/hold/bubble control.
module mem_stage_ctrl #(
  parameter int DW  = 32,
  parameter int PCW = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          ex_valid,
  input  logic [DW-1:0] pc_EX,
  input  logic [DW-1:0] alu_out_EX,
  input  logic [DW-1:0] store_EX,
  input  logic [DW-1:0] imm_EX,
  input  logic [4:0]    wsel_EX,
  input  logic          MemtoReg_EX,
  input  logic          RegWr_EX,
  input  logic          MemRead_EX,
  input  logic          MemWrite_EX,
  input  logic [1:0]    WriteSrc_EX,
  input  logic          flush_in,
  input  logic          hold_in,
  input  logic          dhit,
  input  logic [DW-1:0] dmemload,
  output logic          dREN,
  output logic          dWEN,
  output logic [DW-1:0] dmemaddr,
  output logic [DW-1:0] dmemstore,
  output logic [1:0]    dcache_active,
  output logic [DW-1:0] pc_MEM,
  output logic [DW-1:0] dmem_out,
  output logic [DW-1:0] alu_out_MEM,
  output logic [DW-1:0] imm_MEM,
  output logic [4:0]    wsel_MEM,
  output logic          MemtoReg_MEM,
  output logic          RegWr_MEM,
  output logic [1:0]    WriteSrc_MEM,
  output logic [1:0]    pipeline_ctrl,
  output logic          mem_stall,
  output logic [PCW-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [1:0] PC_LOAD   = 2'b00;
  localparam logic [1:0] PC_HOLD   = 2'b01;
  localparam logic [1:0] PC_BUBBLE = 2'b10;

  state_t        state, next_state;
  logic          req_rd_q, req_wr_q;
  logic          flush_q;
  logic [DW-1:0] load_buf;
  logic [DW-1:0] cap_pc, cap_alu, cap_store, cap_imm;
  logic [4:0]    cap_wsel;
  logic          cap_memtoreg, cap_regwr;
  logic [1:0]    cap_writesrc;

  logic mem_op, op_rd, op_wr;
  logic capture, buf_load, buf_discard, flush_set;

  // A simultaneous read+write request is treated as a write.
  assign mem_op = ex_valid & (MemRead_EX | MemWrite_EX);
  assign op_wr  = MemWrite_EX;
  assign op_rd  = MemRead_EX & ~MemWrite_EX;

  // NOTE: combinational logic uses blocking '=' with a default for every output
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state    = state;
    dREN          = 1'b0;
    dWEN          = 1'b0;
    pipeline_ctrl = PC_LOAD;
    mem_stall     = 1'b0;
    capture       = 1'b0;
    buf_load      = 1'b0;
    buf_discard   = 1'b0;
    flush_set     = 1'b0;
    // Requests are Mealy in IDLE, so reset must gate them to drop asynchronously.
    if (nRST) begin
      unique case (state)
        IDLE: begin
          if (flush_in) begin
            pipeline_ctrl = PC_BUBBLE;
          end else if (mem_op) begin
            dREN    = op_rd;
            dWEN    = op_wr;
            capture = 1'b1;
            if (dhit) begin
              if (hold_in) begin
                buf_load      = 1'b1;
                pipeline_ctrl = PC_HOLD;
                mem_stall     = 1'b1;
                next_state    = DONE;
              end
            end else begin
              pipeline_ctrl = PC_BUBBLE;
              mem_stall     = 1'b1;
              next_state    = WAIT;
            end
          end else if (hold_in) begin
            pipeline_ctrl = PC_HOLD;
            mem_stall     = 1'b1;
          end
        end
        WAIT: begin
          if (flush_in && !req_wr_q) begin
            pipeline_ctrl = PC_BUBBLE;
            next_state    = IDLE;
          end else begin
            dREN = req_rd_q;
            dWEN = req_wr_q;
            if (dhit) begin
              if (flush_in || flush_q) begin
                pipeline_ctrl = PC_BUBBLE;
                next_state    = IDLE;
              end else if (hold_in) begin
                buf_load      = 1'b1;
                pipeline_ctrl = PC_HOLD;
                mem_stall     = 1'b1;
                next_state    = DONE;
              end else begin
                next_state    = IDLE;
              end
            end else begin
              // A write in flight cannot be aborted; remember the flush for completion.
              pipeline_ctrl = PC_BUBBLE;
              mem_stall     = 1'b1;
              flush_set     = flush_in;
            end
          end
        end
        DONE: begin
          if (flush_in) begin
            pipeline_ctrl = PC_BUBBLE;
            buf_discard   = 1'b1;
            next_state    = IDLE;
          end else if (hold_in) begin
            pipeline_ctrl = PC_HOLD;
            mem_stall     = 1'b1;
          end else begin
            next_state    = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign dcache_active = {dWEN, dREN};
  assign dmemaddr      = (state == IDLE) ? alu_out_EX  : cap_alu;
  assign dmemstore     = (state == IDLE) ? store_EX    : cap_store;
  assign dmem_out      = (state == DONE) ? load_buf    : dmemload;
  assign pc_MEM        = (state == IDLE) ? pc_EX       : cap_pc;
  assign alu_out_MEM   = (state == IDLE) ? alu_out_EX  : cap_alu;
  assign imm_MEM       = (state == IDLE) ? imm_EX      : cap_imm;
  assign wsel_MEM      = (state == IDLE) ? wsel_EX     : cap_wsel;
  assign MemtoReg_MEM  = (state == IDLE) ? MemtoReg_EX : cap_memtoreg;
  assign RegWr_MEM     = (state == IDLE) ? RegWr_EX    : cap_regwr;
  assign WriteSrc_MEM  = (state == IDLE) ? WriteSrc_EX : cap_writesrc;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; the payload registers are reset too so they never carry X.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      req_rd_q     <= 1'b0;
      req_wr_q     <= 1'b0;
      flush_q      <= 1'b0;
      load_buf     <= '0;
      cap_pc       <= '0;
      cap_alu      <= '0;
      cap_store    <= '0;
      cap_imm      <= '0;
      cap_wsel     <= '0;
      cap_memtoreg <= 1'b0;
      cap_regwr    <= 1'b0;
      cap_writesrc <= '0;
      stall_cnt    <= '0;
    end else begin
      state   <= next_state;
      flush_q <= (next_state == WAIT) ? (flush_q | flush_set) : 1'b0;
      if (capture) begin
        req_rd_q     <= op_rd;
        req_wr_q     <= op_wr;
        cap_pc       <= pc_EX;
        cap_alu      <= alu_out_EX;
        cap_store    <= store_EX;
        cap_imm      <= imm_EX;
        cap_wsel     <= wsel_EX;
        cap_memtoreg <= MemtoReg_EX;
        cap_regwr    <= RegWr_EX;
        cap_writesrc <= WriteSrc_EX;
      end
      if (buf_load) begin
        load_buf <= dmemload;
      end else if (buf_discard) begin
        load_buf <= '0;
      end
      if (mem_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
